ps2_key_gen: RTL and testbench
==============================

Name: ps2_key_gen

Overview:
- Deserialises a PS/2 keyboard line (device-to-host only) into scan-code bytes.
- Groups prefix bytes into complete key events and publishes them on the 65-bit toggle-flagged ps2_key event word that core-level keyboard decoders consume.
- Sits between the board-level PS/2 pins and any core's key decoder.
- Lets cores run keyboard input without the HPS path, and provides a bit-exact event source for simulation benches.

Parameters:
- FILTER, 8: number of consecutive clk_sys samples for which the synchronised ps2_clk must be stable before a level change is accepted.
- TIMEOUT, 50000: clk_sys cycles without an accepted falling edge, mid-frame, after which the frame is aborted. This is about 1 ms at 50 MHz.

Ports:
- clk_sys, input, 1: system clock; all logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- ps2_clk, input, 1: raw PS/2 clock, asynchronous.
- ps2_data, input, 1: raw PS/2 data, asynchronous.
- ps2_key, output, 65: event word. [63:0] holds the byte history of the event, newest byte in [7:0]. Bit [64] toggles once per completed event.
- byte_valid, output, 1: one-cycle pulse when a byte passes parity and stop checks.
- byte_data, output, 8: last good byte; valid while byte_valid is high and held afterwards.
- frame_err, output, 1: one-cycle pulse on a parity error, bad stop bit, bad start bit or timeout.

Behaviour:
- Clock is one synchronous, active-high reset (reset), and clk_sys.
- Reset: ps2_key = 0, byte_data = 0, byte_valid = 0, frame_err = 0, FSM = IDLE, sequence register cleared, filtered clock = 1.
- A reset asserted mid-frame discards the partial byte.
- Input conditioning: ps2_clk and ps2_data each pass through a 2-FF synchroniser. The filtered clock changes only after FILTER equal consecutive synchronised samples. Data is sampled on the cycle a filtered falling edge is detected.
- FSM is IDLE -> DATA -> PARITY -> STOP -> IDLE, advancing on filtered falling edges.
  - IDLE: data 0 goes to DATA with bit count 0. Data 1 pulses frame_err and stays in IDLE.
  - DATA: shift data in LSB first. After the 8th bit go to PARITY.
  - PARITY: latch the bit. Odd parity across 8 data bits plus the parity bit is required.
  - STOP: data must be 1.
    - If parity and stop are good, byte_valid pulses one cycle after the STOP edge (latency = 1 clk_sys).
    - If not, frame_err pulses on that same cycle instead.
  - In either case the FSM returns to IDLE.
- Timeout:
  - A cycle counter resets on every accepted falling edge and runs only outside IDLE.
  - Reaching TIMEOUT gives frame_err, IDLE, and clears the sequence.
- Any frame_err also clears the sequence register and the pending state. ps2_key itself is not modified.
- Event assembly, on each byte_valid:
  - If the sequence register is empty, it is loaded with {56'h0, byte}. Otherwise it becomes {seq[55:0], byte}.
  - The event stays open, with no publish, while any of these holds:
    - the byte is E0 or F0;
    - the sequence started with E1 and fewer than 8 bytes have been collected;
    - the sequence so far is exactly E0 12 (PrtScr make, first half);
    - the sequence so far is exactly E0 F0 7C (PrtScr break, first half).
  - Otherwise the event is published: ps2_key[63:0] = the new sequence value, ps2_key[64] inverts, and the sequence register clears. All of this happens in the same cycle, so ps2_key updates 1 cycle after byte_valid.
- Consumer-visible rules:
  - Release is [15:8] == F0.
  - Extended is [15:8] == E0, or [23:16] == E0 for a release.
  - Multi-byte keys (PrtScr, Pause) leave [63:24] nonzero.
- A 9th byte in a sequence cannot occur, because E1 closes at 8. Overflow beyond 64 bits discards the oldest byte.
- The toggle bit is never pulsed. It changes exactly once per event, including back-to-back events.

Test Plan:
- Frame with byte 1C, parity 0, stop 1 at a 12 kHz PS/2 clock -> byte_valid with byte_data = 1C. ps2_key[63:0] = 0x1C and [64] goes 0 to 1.
- Bytes F0, 1C -> a single toggle. ps2_key[15:0] = F01C and [63:16] = 0. No publish after F0 alone.
- Bytes E0 F0 75 -> one event with ps2_key[23:0] = E0F075. Then byte 29 -> ps2_key = 0x29 with [64] toggled again, and the history is cleared.
- Pause: E1 14 77 E1 F0 14 F0 77 -> exactly one toggle, ps2_key[63:0] = E11477E1F014F077.
- PrtScr make E0 12 E0 7C -> one toggle with [31:0] = E012E07C. PrtScr break E0 F0 7C E0 F0 12 -> one toggle with [47:0] = E0F07CE0F012.
- Error and glitch handling:
  - A wrong parity bit on byte 1C gives a frame_err pulse, no byte_valid, and ps2_key unchanged.
  - Stopping after 4 data bits gives frame_err after TIMEOUT cycles. The next full frame 1C then decodes correctly.
  - A 3-cycle low glitch on ps2_clk produces no state change.
  - Reset asserted after the F0 byte means a following 1C publishes ps2_key = 0x1C with [64] = 1.

Source files
------------

// File: rtl/ps2_key_gen.sv
// PS/2 keyboard receiver: conditions the raw PS/2 clock/data pins, deserialises
// device-to-host frames into scan-code bytes, and groups prefix bytes into
// complete key events on a 65-bit toggle-flagged ps2_key word.
module ps2_key_gen #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [64:0] ps2_key,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        frame_err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    // Input conditioning
    logic          clk_meta_q, clk_sync_q;
    logic          data_meta_q, data_sync_q;
    logic          filt_clk_q, filt_clk_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fall;

    // Frame receiver
    logic [1:0]    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic [7:0]    byte_q, byte_d;

    // Event assembly
    logic [55:0]   seq_q, seq_d;
    logic [3:0]    seq_cnt_q, seq_cnt_d;
    logic          e1_q, e1_d;
    logic [64:0]   key_q, key_d;
    logic [63:0]   new_seq;
    logic [3:0]    new_cnt;
    logic          starts_e1;
    logic          hold;

    // Glitch filter: the filtered clock follows the synchronised clock only
    // after FILTER consecutive samples disagree with the current filtered level.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned, which would infer a latch.
        filt_clk_d = filt_clk_q;
        filt_cnt_d = '0;
        if (clk_sync_q != filt_clk_q) begin
            if (filt_cnt_q == FW'(FILTER - 1)) begin
                filt_clk_d = clk_sync_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    assign fall = filt_clk_q & ~filt_clk_d;

    // Two-flop synchronisers and filter state; the idle line level is high.
    always_ff @(posedge clk_sys) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            filt_clk_q  <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            clk_meta_q  <= ps2_clk;
            clk_sync_q  <= clk_meta_q;
            data_meta_q <= ps2_data;
            data_sync_q <= data_meta_q;
            filt_clk_q  <= filt_clk_d;
            filt_cnt_q  <= filt_cnt_d;
        end
    end

    // Frame FSM: advances on filtered falling edges, aborts on a stalled frame.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tmo_d     = tmo_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        byte_d    = byte_q;
        if (fall) begin
            tmo_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (!data_sync_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_d   = {data_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_d = data_sync_q;
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    // Odd parity over data plus parity bit, and a high stop bit.
                    if ((^{shift_q, parity_q}) && data_sync_q) begin
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q == ST_IDLE) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            tmo_d   = '0;
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // Frame FSM registers; a reset mid-frame drops the partial byte.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tmo_q     <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            byte_q    <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tmo_q     <= tmo_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            byte_q    <= byte_d;
        end
    end

    // Event assembly: accumulate prefix bytes, publish complete key events.
    always_comb begin
        seq_d     = seq_q;
        seq_cnt_d = seq_cnt_q;
        e1_d      = e1_q;
        key_d     = key_q;
        // The held history is zero when empty, so one shift form covers both
        // the first byte and later ones; only 7 held bytes can reach the event.
        new_seq   = {seq_q, byte_q};
        new_cnt   = (seq_cnt_q == 4'd8) ? 4'd8 : seq_cnt_q + 4'd1;
        starts_e1 = (seq_cnt_q == 4'd0) ? (byte_q == 8'hE1) : e1_q;
        hold      = (byte_q == 8'hE0) || (byte_q == 8'hF0)
                 || (starts_e1 && (new_cnt < 4'd8))
                 || ((new_cnt == 4'd2) && (new_seq[15:0] == 16'hE012))
                 || ((new_cnt == 4'd3) && (new_seq[23:0] == 24'hE0F07C));
        if (err_q) begin
            seq_d     = '0;
            seq_cnt_d = '0;
            e1_d      = 1'b0;
        end else if (valid_q) begin
            if (hold) begin
                seq_d     = new_seq[55:0];
                seq_cnt_d = new_cnt;
                e1_d      = starts_e1;
            end else begin
                key_d     = {~key_q[64], new_seq};
                seq_d     = '0;
                seq_cnt_d = '0;
                e1_d      = 1'b0;
            end
        end
    end

    // Event assembly registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            seq_q     <= '0;
            seq_cnt_q <= '0;
            e1_q      <= 1'b0;
            key_q     <= '0;
        end else begin
            seq_q     <= seq_d;
            seq_cnt_q <= seq_cnt_d;
            e1_q      <= e1_d;
            key_q     <= key_d;
        end
    end

    assign ps2_key    = key_q;
    assign byte_valid = valid_q;
    assign byte_data  = byte_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_ps2_key_gen.sv
// Bench for ps2_key_gen: a 12 kHz PS/2 device model against a 1 MHz clk_sys,
// with a scoreboard of expected bytes and published key words.
`timescale 1ns/1ps
module tb_ps2_key_gen;

    localparam int FILTER  = 8;
    localparam int TIMEOUT = 1000;
    localparam int HALF    = 42;   // half PS/2 period in clk_sys cycles

    logic        clk_sys  = 1'b0;
    logic        reset    = 1'b1;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [64:0] ps2_key;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        frame_err;

    ps2_key_gen #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .ps2_key    (ps2_key),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    always #500 clk_sys = ~clk_sys;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int err_seen = 0;
    int err_cyc  = 0;
    int fall_cyc = 0;

    logic [7:0]  exp_bytes[$];
    logic [64:0] exp_keys[$];
    logic        exp_tog     = 1'b0;
    logic [64:0] exp_key_now = '0;
    logic [64:0] last_key    = '0;
    logic [7:0]  mon_b;
    logic [64:0] mon_k;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard whenever the DUT produces something.
    always @(negedge clk_sys) begin
        if (reset) begin
            last_key = ps2_key;
        end else begin
            if (byte_valid) begin
                total++;
                if (exp_bytes.size() == 0) begin
                    bad++;
                    $display("FAIL byte_unexpected: got %h, none expected", byte_data);
                end else begin
                    mon_b = exp_bytes.pop_front();
                    if (byte_data !== mon_b) begin
                        bad++;
                        $display("FAIL byte_data: got %h, want %h", byte_data, mon_b);
                    end
                end
            end
            if (ps2_key !== last_key) begin
                total++;
                if (exp_keys.size() == 0) begin
                    bad++;
                    $display("FAIL key_unexpected: got %h, none expected", ps2_key);
                end else begin
                    mon_k = exp_keys.pop_front();
                    if (ps2_key !== mon_k) begin
                        bad++;
                        $display("FAIL ps2_key: got %h, want %h", ps2_key, mon_k);
                    end
                end
                last_key = ps2_key;
            end
            if (frame_err) begin
                err_seen++;
                err_cyc = cyc;
            end
        end
    end

    function automatic logic [10:0] frame(input logic [7:0] b, input logic par_flip,
                                          input logic stop);
        return {stop, (~(^b)) ^ par_flip, b, 1'b0};
    endfunction

    // Device model: data changes while the clock is high, host samples on fall.
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_sys);
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk_sys);
            ps2_clk  = 1'b0;
            fall_cyc = cyc;
            repeat (HALF) @(negedge clk_sys);
            ps2_clk  = 1'b1;
        end
        repeat (HALF) @(negedge clk_sys);
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit publish, input logic [63:0] key);
        exp_bytes.push_back(b);
        if (publish) begin
            exp_tog     = ~exp_tog;
            exp_key_now = {exp_tog, key};
            exp_keys.push_back(exp_key_now);
        end
        send_bits(frame(b, 1'b0, 1'b1), 11);
        repeat (20) @(negedge clk_sys);
    endtask

    // Sends n bytes oldest first; only the last one is expected to publish.
    task automatic send_event(input logic [63:0] bytes, input int n);
        for (int i = 0; i < n; i++) begin
            send_byte(bytes[8*(n-1-i) +: 8], (i == n - 1), bytes);
        end
    endtask

    task automatic settle(input string name);
        repeat (30) @(negedge clk_sys);
        total++;
        if (exp_bytes.size() != 0 || exp_keys.size() != 0) begin
            bad++;
            $display("FAIL %s_pending: bytes=%0d keys=%0d left, want 0", name,
                     exp_bytes.size(), exp_keys.size());
            exp_bytes.delete();
            exp_keys.delete();
        end
        total++;
        if (ps2_key !== exp_key_now) begin
            bad++;
            $display("FAIL %s_key: got %h, want %h", name, ps2_key, exp_key_now);
        end
    endtask

    task automatic check_errs(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s_frame_err: got %0d pulses, want %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(negedge clk_sys);
        total++;
        if (ps2_key !== 65'h0 || byte_data !== 8'h00 || byte_valid !== 1'b0
            || frame_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: key=%h data=%h valid=%b err=%b, want all 0",
                     ps2_key, byte_data, byte_valid, frame_err);
        end
        reset = 1'b0;
        repeat (5) @(negedge clk_sys);
    endtask

    task automatic test_single();
        send_byte(8'h1C, 1'b1, 64'h1C);
        settle("single");
        total++;
        if (ps2_key[64] !== 1'b1 || byte_data !== 8'h1C) begin
            bad++;
            $display("FAIL single_toggle: toggle=%b data=%h, want 1 and 1c",
                     ps2_key[64], byte_data);
        end
    endtask

    task automatic test_release();
        send_byte(8'hF0, 1'b0, 64'h0);
        settle("release_f0_only");
        send_byte(8'h1C, 1'b1, 64'hF01C);
        settle("release");
    endtask

    task automatic test_ext_release();
        send_event(64'hE0F075, 3);
        settle("ext_release");
        send_byte(8'h29, 1'b1, 64'h29);
        settle("after_ext");
    endtask

    task automatic test_multi_byte();
        send_event(64'hE11477E1F014F077, 8);
        settle("pause");
        send_event(64'hE012E07C, 4);
        settle("prtscr_make");
        send_event(64'hE0F07CE0F012, 6);
        settle("prtscr_break");
    endtask

    task automatic test_errors();
        int e0;
        e0 = err_seen;
        send_byte(8'hF0, 1'b0, 64'h0);
        send_bits(frame(8'h1C, 1'b1, 1'b1), 11);
        repeat (20) @(negedge clk_sys);
        check_errs("parity", err_seen - e0, 1);
        settle("parity");
        send_bits(frame(8'h1C, 1'b0, 1'b0), 11);
        repeat (20) @(negedge clk_sys);
        check_errs("stop", err_seen - e0, 2);
        send_bits(11'h7FF, 1);
        repeat (20) @(negedge clk_sys);
        check_errs("start", err_seen - e0, 3);
        settle("bad_frames");
        // The F0 held before the parity error must have been discarded.
        send_byte(8'h1C, 1'b1, 64'h1C);
        settle("after_errors");
    endtask

    task automatic test_timeout();
        int e0;
        int waited;
        e0 = err_seen;
        send_bits(frame(8'h1C, 1'b0, 1'b1), 5);
        waited = 0;
        while (err_seen == e0 && waited < 3 * TIMEOUT) begin
            @(negedge clk_sys);
            waited++;
        end
        total++;
        if (err_seen == e0) begin
            bad++;
            $display("FAIL timeout_wait: no frame_err within %0d cycles", 3 * TIMEOUT);
        end else if (err_cyc - fall_cyc < TIMEOUT || err_cyc - fall_cyc > TIMEOUT + FILTER + 6) begin
            bad++;
            $display("FAIL timeout_latency: got %0d cycles, want %0d..%0d",
                     err_cyc - fall_cyc, TIMEOUT, TIMEOUT + FILTER + 6);
        end
        settle("timeout");
        send_byte(8'h1C, 1'b1, 64'h1C);
        settle("after_timeout");
    endtask

    task automatic test_glitch();
        int e0;
        e0 = err_seen;
        @(negedge clk_sys);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk_sys);
        ps2_clk = 1'b1;
        repeat (30) @(negedge clk_sys);
        check_errs("glitch", err_seen - e0, 0);
        settle("glitch");
        send_byte(8'h5A, 1'b1, 64'h5A);
        settle("after_glitch");
    endtask

    task automatic test_reset_mid();
        send_byte(8'hF0, 1'b0, 64'h0);
        send_bits(frame(8'h33, 1'b0, 1'b1), 5);
        @(negedge clk_sys);
        reset = 1'b1;
        repeat (3) @(negedge clk_sys);
        exp_tog     = 1'b0;
        exp_key_now = '0;
        total++;
        if (ps2_key !== 65'h0) begin
            bad++;
            $display("FAIL reset_mid_key: got %h, want 0", ps2_key);
        end
        reset = 1'b0;
        repeat (5) @(negedge clk_sys);
        send_byte(8'h1C, 1'b1, 64'h1C);
        settle("reset_mid");
        total++;
        if (ps2_key !== {1'b1, 64'h1C}) begin
            bad++;
            $display("FAIL reset_mid_final: got %h, want 1_000000000000001c", ps2_key);
        end
    endtask

    task automatic test_back_to_back();
        send_byte(8'h1C, 1'b1, 64'h1C);
        send_byte(8'h32, 1'b1, 64'h32);
        settle("back_to_back");
    endtask

    initial begin
        test_reset();
        test_single();
        test_release();
        test_ext_release();
        test_multi_byte();
        test_errors();
        test_timeout();
        test_glitch();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #90ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
